dpb_stream_fifo: RTL and testbench



---
 rtl/dpb_fifo_pkg.sv | 16 +
 rtl/dpb_skid2.sv | 72 +++++++
 rtl/dpb_stream_fifo.sv | 103 ++++++++++
 tb/tb_dpb_stream_fifo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dpb_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpb_fifo_pkg : shared widths and types for the dpb stream FIFO       |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package dpb_fifo_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 7;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;
  localparam int SKID_CNT_W = 2;

  typedef logic [SKID_CNT_W-1:0] skid_cnt_t;

endpackage
`default_nettype wire

// File: rtl/dpb_skid2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpb_skid2 : 2-entry output skid buffer, head drives the stream port  |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module dpb_skid2
  import dpb_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] dout_o,
  output skid_cnt_t         cnt_o
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  skid_cnt_t         cnt_q, cnt_d;
  logic              valid_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = din_i;
        else               tail_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the count; the new word lands behind any survivor.
        if (cnt_q == 2'd2) begin
          head_d = tail_q;
          tail_d = din_i;
        end else begin
          head_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != 2'd0);
    end
  end

  assign valid_o = valid_q;
  assign dout_o  = head_q;
  assign cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: rtl/dpb_stream_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpb_stream_fifo : FWFT valid/ready FIFO controller for a 128x16 DPRAM |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module dpb_stream_fifo
  import dpb_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W+1:0] level,
  output logic              overflow,
  output logic              ram_cea,
  output logic              ram_wrea,
  output logic [ADDR_W-1:0] ram_ada,
  output logic [DATA_W-1:0] ram_dina,
  output logic              ram_ceb,
  output logic [ADDR_W-1:0] ram_adb,
  input  logic [DATA_W-1:0] ram_doutb,
  output logic              ram_ocea,
  output logic              ram_oceb,
  output logic              ram_wreb,
  output logic              ram_reseta,
  output logic              ram_resetb
);

  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic              inflight_q;
  logic              s_ready_q;
  logic              overflow_q;
  skid_cnt_t         skid_cnt;
  logic              w_wr, w_rd, w_pop;
  logic [2:0]        w_occ;

  assign w_wr  = s_valid & s_ready_q;
  assign w_pop = m_valid & m_ready;
  assign w_occ = {1'b0, skid_cnt} + {2'b00, inflight_q};
  // Read decision uses registered ram_cnt, so it never targets the slot written this edge.
  assign w_rd  = (ram_cnt_q != '0) && (w_occ < ({2'b00, w_pop} + 3'd2));

  assign ram_cnt_d = ram_cnt_q + {{ADDR_W{1'b0}}, w_wr} - {{ADDR_W{1'b0}}, w_rd};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      s_ready_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (w_wr) wptr_q <= wptr_q + 1'b1;
      if (w_rd) rptr_q <= rptr_q + 1'b1;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= w_rd;
      // ram_cnt tops out at 2**ADDR_W, so its MSB alone flags full.
      s_ready_q  <= ~ram_cnt_d[ADDR_W];
      overflow_q <= overflow_q | (s_valid & ~s_ready_q);
    end
  end

  dpb_skid2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (inflight_q),
    .pop_i   (w_pop),
    .din_i   (ram_doutb),
    .valid_o (m_valid),
    .dout_o  (m_data),
    .cnt_o   (skid_cnt)
  );

  assign s_ready  = s_ready_q;
  assign overflow = overflow_q;
  assign level    = {1'b0, ram_cnt_q} + {{(ADDR_W+1){1'b0}}, inflight_q}
                  + {{ADDR_W{1'b0}}, skid_cnt};

  assign ram_cea    = w_wr;
  assign ram_wrea   = w_wr;
  assign ram_ada    = wptr_q;
  assign ram_dina   = s_data;
  assign ram_ceb    = w_rd;
  assign ram_adb    = rptr_q;
  assign ram_ocea   = 1'b1;
  assign ram_oceb   = 1'b1;
  assign ram_wreb   = 1'b0;
  assign ram_reseta = 1'b0;
  assign ram_resetb = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_dpb_stream_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dpb_stream_fifo : directed + random bench with RAM model          |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module tb_dpb_stream_fifo;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              resetn;
  logic              s_valid, s_ready, m_valid, m_ready, overflow;
  logic [DATA_W-1:0] s_data, m_data;
  logic [ADDR_W+1:0] level;
  logic              ram_cea, ram_wrea, ram_ceb;
  logic [ADDR_W-1:0] ram_ada, ram_adb;
  logic [DATA_W-1:0] ram_dina, ram_doutb;
  logic              ram_ocea, ram_oceb, ram_wreb, ram_reseta, ram_resetb;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] sb [$];
  int vectors = 0;
  int miscompares = 0;
  int n_pop = 0;

  always #5 clk = ~clk;

  dpb_stream_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level), .overflow(overflow),
    .ram_cea(ram_cea), .ram_wrea(ram_wrea), .ram_ada(ram_ada), .ram_dina(ram_dina),
    .ram_ceb(ram_ceb), .ram_adb(ram_adb), .ram_doutb(ram_doutb),
    .ram_ocea(ram_ocea), .ram_oceb(ram_oceb), .ram_wreb(ram_wreb),
    .ram_reseta(ram_reseta), .ram_resetb(ram_resetb)
  );

  // Block RAM: port A write, port B registered read
  always @(posedge clk) begin
    if (ram_cea && ram_wrea) mem[ram_ada] <= ram_dina;
    if (ram_ceb) ram_doutb <= mem[ram_adb];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accepted input, pop/compare on accepted output
  always @(negedge clk) begin
    if (resetn) begin
      if (m_valid && m_ready) begin
        assert (sb.size() != 0) else begin
          miscompares++;
          $error("FAIL sb_underflow observed=%0h expected=none", m_data);
        end
        if (sb.size() != 0) begin
          chk("sb_data", {16'h0, m_data}, {16'h0, sb.pop_front()});
          n_pop++;
        end
      end
      if (s_valid && s_ready) sb.push_back(s_data);
    end
  end

  initial begin
    resetn = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    repeat (3) step();
    chk("rst_s_ready", {31'h0, s_ready}, 32'h0);
    chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
    chk("rst_level", {23'h0, level}, 32'h0);
    chk("rst_m_data", {16'h0, m_data}, 32'h0);
    chk("rst_ram_ceb", {31'h0, ram_ceb}, 32'h0);
    resetn = 1'b1;
    step();
    chk("rel_s_ready", {31'h0, s_ready}, 32'h1);

    // Single word latency
    s_valid = 1'b1; s_data = 16'hA5A5;
    step();
    s_valid = 1'b0;
    chk("t1_ceb", {31'h0, ram_ceb}, 32'h1);
    chk("t1_level_a", {23'h0, level}, 32'h1);
    step();
    chk("t1_mvalid_early", {31'h0, m_valid}, 32'h0);
    step();
    chk("t1_mvalid", {31'h0, m_valid}, 32'h1);
    chk("t1_mdata", {16'h0, m_data}, 32'hA5A5);
    chk("t1_level_b", {23'h0, level}, 32'h1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("t1_mvalid_drop", {31'h0, m_valid}, 32'h0);
    chk("t1_level_c", {23'h0, level}, 32'h0);

    // Fill with consumer stalled
    for (int i = 0; i < 130; i++) begin
      chk("fill_rdy", {31'h0, s_ready}, 32'h1);
      s_valid = 1'b1; s_data = 16'(i);
      step();
    end
    chk("full_s_ready", {31'h0, s_ready}, 32'h0);
    chk("full_level", {23'h0, level}, 32'd130);
    chk("full_ovf_clr", {31'h0, overflow}, 32'h0);
    s_data = 16'h0082;
    step();
    s_valid = 1'b0;
    chk("full_ovf_set", {31'h0, overflow}, 32'h1);

    // Drain
    n_pop = 0;
    m_ready = 1'b1;
    step();
    chk("drain_s_ready", {31'h0, s_ready}, 32'h1);
    for (int k = 0; k < 300 && level != '0; k++) step();
    step();
    chk("drain_count", n_pop, 32'd130);
    chk("drain_level", {23'h0, level}, 32'h0);
    chk("drain_mvalid", {31'h0, m_valid}, 32'h0);

    // Full-rate streaming
    s_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s_data = 16'(16'h1000 + i);
      step();
      if (i >= 2) chk("stream_mvalid", {31'h0, m_valid}, 32'h1);
      chk("stream_s_ready", {31'h0, s_ready}, 32'h1);
    end
    s_valid = 1'b0;
    for (int k = 0; k < 20 && level != '0; k++) step();
    chk("stream_level", {23'h0, level}, 32'h0);

    // Random backpressure
    for (int i = 0; i < 800; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = 16'($urandom);
      step();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 300 && level != '0; k++) step();
    step();
    chk("rand_level", {23'h0, level}, 32'h0);
    chk("rand_sb_empty", sb.size(), 32'h0);

    // Reset mid-stream
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 16'(16'h7700 + i);
      step();
    end
    s_valid = 1'b0;
    #1;
    resetn = 1'b0;
    sb.delete();
    #1;
    chk("mrst_s_ready", {31'h0, s_ready}, 32'h0);
    chk("mrst_m_valid", {31'h0, m_valid}, 32'h0);
    chk("mrst_m_data", {16'h0, m_data}, 32'h0);
    chk("mrst_level", {23'h0, level}, 32'h0);
    chk("mrst_ceb", {31'h0, ram_ceb}, 32'h0);
    chk("mrst_cea", {31'h0, ram_cea}, 32'h0);
    repeat (2) step();
    resetn = 1'b1;
    step();
    chk("mrst_rel_rdy", {31'h0, s_ready}, 32'h1);
    s_valid = 1'b1; s_data = 16'hBEEF;
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 10 && !m_valid; k++) step();
    chk("mrst_mvalid", {31'h0, m_valid}, 32'h1);
    chk("mrst_mdata", {16'h0, m_data}, 32'hBEEF);
    m_ready = 1'b1;
    step();
    chk("mrst_level", {23'h0, level}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
